// File: rtl/dt_repack.sv
// ============================================================================
// dt_repack
//
// Purpose:
//   Post-processing stage of the distance-transform subsystem. It streams the
//   IMG_W x IMG_W distance map out of result RAM one pixel per cycle. Each
//   pixel is thresholded to one bit (bit = pixel >= threshold, unsigned). The
//   bits are packed 16 per word, first pixel in the MSB, and each word is
//   written to the packed binary image RAM. The packed format matches what
//   the transform engine consumes.
//
// Optional feature (macro DT_REPACK_POPCNT_EN):
//   When the macro is defined, output pop_count is added. It gives the number
//   of 1-bits written during the most recent run.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-low reset
//   start      in   single-cycle start request, accepted only in IDLE
//   threshold  in   pixel threshold, sampled when start is accepted
//   busy       out  high while a conversion is in progress
//   done       out  single-cycle completion pulse
//   res_rd     out  result RAM read enable
//   res_addr   out  result RAM pixel address
//   res_di     in   result RAM read data, valid the cycle after res_rd
//   sti_wr     out  packed-image RAM write enable
//   sti_addr   out  packed-image word address
//   sti_do     out  packed-image write data
//   pop_count  out  count of 1 pixels in the run (DT_REPACK_POPCNT_EN only)
// ============================================================================
module dt_repack #(
    parameter int IMG_W  = 128,
    parameter int PIX_W  = 8,
    parameter int WORD_W = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [PIX_W-1:0]                        threshold,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    res_rd,
    output logic [$clog2(IMG_W*IMG_W)-1:0]          res_addr,
    input  logic [PIX_W-1:0]                        res_di,
    output logic                                    sti_wr,
    output logic [$clog2(IMG_W*IMG_W/WORD_W)-1:0]   sti_addr,
    output logic [WORD_W-1:0]                       sti_do
`ifdef DT_REPACK_POPCNT_EN
    ,
    output logic [$clog2(IMG_W*IMG_W+1)-1:0]        pop_count
`endif
);

    localparam int PIX_N   = IMG_W * IMG_W;
    localparam int ADDR_W  = $clog2(PIX_N);
    localparam int WORDS   = PIX_N / WORD_W;
    localparam int WADDR_W = $clog2(WORDS);
    localparam int IDX_W   = $clog2(WORD_W);

    localparam logic [ADDR_W-1:0]  LAST_PIX  = ADDR_W'(PIX_N - 1);
    localparam logic [WADDR_W-1:0] LAST_WORD = WADDR_W'(WORDS - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [PIX_W-1:0]   thr_reg;
    logic               cap_vld;
    logic [IDX_W-1:0]   cap_idx;
    logic [WADDR_W-1:0] word_cnt;
    logic [WORD_W-2:0]  shreg;
    logic               accept;
    logic               pix_bit;

    assign accept  = (state == IDLE) && start;
    assign pix_bit = (res_di >= thr_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The run ends on the final word write, not on the pixel counter.
    // Capture still lags the reads by one cycle and the write by one more.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = READ;
            READ:    if (res_addr == LAST_PIX) state_next = DRAIN;
            DRAIN:   if (sti_wr && (sti_addr == LAST_WORD)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status and read-port outputs are decoded from the next state.
    // This keeps them registered and aligned with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            res_rd   <= 1'b0;
            res_addr <= '0;
            thr_reg  <= '0;
        end else begin
            busy   <= (state_next == READ) || (state_next == DRAIN);
            done   <= (state_next == DONE);
            res_rd <= (state_next == READ);
            if (accept) begin
                thr_reg  <= threshold;
                res_addr <= '0;
            end else if ((state == READ) && (res_addr != LAST_PIX)) begin
                res_addr <= res_addr + 1'b1;
            end
        end
    end

    // cap_vld marks the cycle where RAM data for the previous read is present.
    // The 16th bit of a word goes straight into sti_do, bypassing the shift
    // register, so the write happens the cycle after the last capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_vld  <= 1'b0;
            cap_idx  <= '0;
            word_cnt <= '0;
            shreg    <= '0;
            sti_wr   <= 1'b0;
            sti_addr <= '0;
            sti_do   <= '0;
        end else begin
            cap_vld <= res_rd;
            sti_wr  <= 1'b0;
            if (accept) begin
                cap_idx  <= '0;
                word_cnt <= '0;
                shreg    <= '0;
            end else if (cap_vld) begin
                shreg   <= {shreg[WORD_W-3:0], pix_bit};
                cap_idx <= cap_idx + 1'b1;
                if (cap_idx == LAST_IDX) begin
                    sti_wr   <= 1'b1;
                    sti_addr <= word_cnt;
                    sti_do   <= {shreg, pix_bit};
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

`ifdef DT_REPACK_POPCNT_EN
    // Counts every captured 1 pixel. It holds after the run until the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_count <= '0;
        end else if (accept) begin
            pop_count <= '0;
        end else if (cap_vld && pix_bit) begin
            pop_count <= pop_count + 1'b1;
        end
    end
`endif

endmodule
